mtx_host_if: RTL and testbench

Host-side endpoint for the 4x4 complex bidiagonalization core. Holds a 16-entry complex channel-matrix buffer loaded by the host and streams it to the core as one valid-framed burst. Captures the core's 16-sample result burst into a separate result buffer and signals completion. Used as the system-level wrapper and bench driver around the core.

---
 rtl/mtx_host_if.sv | 166 ++++++++++++++++
 tb/tb_mtx_host_if.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_host_if.sv
// Host endpoint: loads a 16-sample complex matrix, streams it as one valid-framed burst, captures the 16-beat result.
// Latency: start at T -> lead beat at T+1, samples T+2..T+17; done one cycle after the 16th result beat.
// No backpressure: the burst is unconditional; MTX_HOST_TIMEOUT_EN adds a result-gap watchdog driving err_timeout.
module mtx_host_if #(
    parameter int BIT_NUM      = 18,
    parameter int CHANNEL_SIZE = 16,
    parameter int LEAD_BEATS   = 1,
    parameter int TIMEOUT      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_we,
    input  logic [3:0]                load_addr,
    input  logic signed [BIT_NUM-1:0] load_r,
    input  logic signed [BIT_NUM-1:0] load_i,
    input  logic                      start,
    output logic                      busy,
    output logic                      tx_valid,
    output logic signed [BIT_NUM-1:0] tx_r,
    output logic signed [BIT_NUM-1:0] tx_i,
    input  logic                      rx_valid,
    input  logic signed [BIT_NUM-1:0] rx_r,
    input  logic signed [BIT_NUM-1:0] rx_i,
    input  logic [3:0]                rd_addr,
    output logic signed [BIT_NUM-1:0] rd_r,
    output logic signed [BIT_NUM-1:0] rd_i,
    output logic                      done,
    output logic                      err_timeout
);

    typedef enum logic [2:0] {IDLE, LEAD, SEND, WAIT, CAPT, FIN} state_t;

    state_t     state, state_nxt;
    logic [4:0] tx_cnt, tx_cnt_nxt;
    logic [4:0] rx_cnt, rx_cnt_nxt;
    logic       res_we;

    logic signed [BIT_NUM-1:0] mat_r [CHANNEL_SIZE];
    logic signed [BIT_NUM-1:0] mat_i [CHANNEL_SIZE];
    logic signed [BIT_NUM-1:0] res_r [CHANNEL_SIZE];
    logic signed [BIT_NUM-1:0] res_i [CHANNEL_SIZE];

`ifdef MTX_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_cnt, idle_nxt;
    logic            to_fire;
`endif

    always_comb begin
        state_nxt  = state;
        tx_cnt_nxt = tx_cnt;
        rx_cnt_nxt = rx_cnt;
        res_we     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = (LEAD_BEATS > 0) ? LEAD : SEND;
                    tx_cnt_nxt = '0;
                    rx_cnt_nxt = '0;
                end
            end
            // tx_cnt counts lead beats here, then sample indices in SEND
            LEAD: begin
                if (tx_cnt == 5'(LEAD_BEATS - 1)) begin
                    state_nxt  = SEND;
                    tx_cnt_nxt = '0;
                end else begin
                    tx_cnt_nxt = tx_cnt + 5'd1;
                end
            end
            SEND: begin
                if (tx_cnt == 5'(CHANNEL_SIZE - 1)) begin
                    state_nxt = WAIT;
                end else begin
                    tx_cnt_nxt = tx_cnt + 5'd1;
                end
            end
            WAIT, CAPT: begin
                if (rx_valid) begin
                    res_we     = 1'b1;
                    rx_cnt_nxt = rx_cnt + 5'd1;
                    state_nxt  = (rx_cnt == 5'(CHANNEL_SIZE - 1)) ? FIN : CAPT;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

`ifdef MTX_HOST_TIMEOUT_EN
        idle_nxt = '0;
        to_fire  = 1'b0;
        if ((state == WAIT || state == CAPT) && !rx_valid) begin
            if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                to_fire   = 1'b1;
                state_nxt = IDLE;
            end else begin
                idle_nxt = idle_cnt + 1'b1;
            end
        end
`endif
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_r     <= '0;
            tx_i     <= '0;
            done     <= 1'b0;
            for (int k = 0; k < CHANNEL_SIZE; k++) begin
                mat_r[k] <= '0;
                mat_i[k] <= '0;
                res_r[k] <= '0;
                res_i[k] <= '0;
            end
        end else begin
            state    <= state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            rx_cnt   <= rx_cnt_nxt;
            busy     <= (state_nxt != IDLE);
            tx_valid <= (state_nxt == LEAD) || (state_nxt == SEND);
            done     <= (state_nxt == FIN);
            if (state_nxt == SEND) begin
                tx_r <= mat_r[tx_cnt_nxt[3:0]];
                tx_i <= mat_i[tx_cnt_nxt[3:0]];
            end else begin
                tx_r <= '0;
                tx_i <= '0;
            end
            if (state == IDLE && load_we) begin
                mat_r[load_addr] <= load_r;
                mat_i[load_addr] <= load_i;
            end
            if (res_we) begin
                res_r[rx_cnt[3:0]] <= rx_r;
                res_i[rx_cnt[3:0]] <= rx_i;
            end
        end
    end

`ifdef MTX_HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            idle_cnt <= idle_nxt;
            if (state == IDLE && start) begin
                err_timeout <= 1'b0;
            end else if (to_fire) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    assign rd_r = res_r[rd_addr];
    assign rd_i = res_i[rd_addr];

endmodule

// File: tb/tb_mtx_host_if.sv
// Bench for mtx_host_if: vector table drives loads/result beats, scoreboards check tx burst and readback.
module tb_mtx_host_if;

    localparam int BN   = 18;
    localparam int LEAD = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 load_we = 1'b0;
    logic [3:0]           load_addr = '0;
    logic signed [BN-1:0] load_r = '0;
    logic signed [BN-1:0] load_i = '0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 tx_valid;
    logic signed [BN-1:0] tx_r, tx_i;
    logic                 rx_valid = 1'b0;
    logic signed [BN-1:0] rx_r = '0;
    logic signed [BN-1:0] rx_i = '0;
    logic [3:0]           rd_addr = '0;
    logic signed [BN-1:0] rd_r, rd_i;
    logic                 done;
    logic                 err_timeout;

    mtx_host_if #(.BIT_NUM(BN), .CHANNEL_SIZE(16), .LEAD_BEATS(LEAD), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_r(load_r), .load_i(load_i),
        .start(start), .busy(busy),
        .tx_valid(tx_valid), .tx_r(tx_r), .tx_i(tx_i),
        .rx_valid(rx_valid), .rx_r(rx_r), .rx_i(rx_i),
        .rd_addr(rd_addr), .rd_r(rd_r), .rd_i(rd_i),
        .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]           addr;
        logic signed [BN-1:0] ld_r, ld_i;
        logic signed [BN-1:0] rxv_r, rxv_i;
        logic signed [BN-1:0] tx_r, tx_i;
        logic signed [BN-1:0] rd_r, rd_i;
    } vec_t;

    typedef struct {
        logic signed [BN-1:0] r, i;
    } samp_t;

    vec_t  vt [16];
    samp_t exp_tx [$];
    samp_t exp_rd [$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_tx(input logic signed [BN-1:0] r, input logic signed [BN-1:0] i);
        samp_t s;
        s.r = r;
        s.i = i;
        exp_tx.push_back(s);
    endtask

    task automatic push_lead_and_matrix();
        for (int b = 0; b < LEAD; b++) push_tx('0, '0);
        for (int k = 0; k < 16; k++) push_tx(vt[k].tx_r, vt[k].tx_i);
    endtask

    task automatic load_entry(input int k);
        load_we   = 1'b1;
        load_addr = vt[k].addr;
        load_r    = vt[k].ld_r;
        load_i    = vt[k].ld_i;
    endtask

    task automatic load_all();
        for (int k = 15; k >= 0; k--) begin
            load_entry(k);
            tick();
        end
        load_we = 1'b0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start   = 1'b0;
        load_we = 1'b0;
        chk({tag, " lead tx_valid"}, tx_valid, 1'b1);
        chk({tag, " lead busy"}, busy, 1'b1);
    endtask

    // Observes the burst from T+1; optionally injects start/load_we at a given beat count.
    task automatic watch_burst(input string tag, input int inject_at);
        int    beats = 0;
        int    dones = 0;
        samp_t e;
        for (int c = 0; c < 40; c++) begin
            if (done) dones++;
            if (!tx_valid) break;
            if (exp_tx.size() != 0) begin
                e = exp_tx.pop_front();
                chk($sformatf("%s tx_r[%0d]", tag, beats), tx_r, e.r);
                chk($sformatf("%s tx_i[%0d]", tag, beats), tx_i, e.i);
            end
            beats++;
            if (beats == inject_at) begin
                start     = 1'b1;
                load_we   = 1'b1;
                load_addr = 4'd5;
                load_r    = 18'sd777;
                load_i    = -18'sd777;
            end
            tick();
            start   = 1'b0;
            load_we = 1'b0;
        end
        chk({tag, " beats"}, beats, 16 + LEAD);
        chk({tag, " no done"}, dones, 0);
        exp_tx.delete();
    endtask

    task automatic drive_rx(input string tag, input int gap);
        int    early = 0;
        samp_t s;
        for (int k = 0; k < 16; k++) begin
            rx_valid = 1'b1;
            rx_r     = vt[k].rxv_r;
            rx_i     = vt[k].rxv_i;
            s.r = vt[k].rd_r;
            s.i = vt[k].rd_i;
            exp_rd.push_back(s);
            tick();
            rx_valid = 1'b0;
            rx_r     = 18'sh1aaaa;
            rx_i     = 18'sh15555;
            if (k < 15) begin
                if (done) early++;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (done) early++;
                end
            end
        end
        chk({tag, " done early"}, early, 0);
        chk({tag, " done E+1"}, done, 1'b1);
        chk({tag, " busy E+1"}, busy, 1'b1);
        tick();
        chk({tag, " done E+2"}, done, 1'b0);
        chk({tag, " busy E+2"}, busy, 1'b0);
    endtask

    task automatic read_check(input string tag);
        samp_t e;
        for (int k = 0; k < 16; k++) begin
            rd_addr = 4'(k);
            #1;
            if (exp_rd.size() != 0) begin
                e = exp_rd.pop_front();
                chk($sformatf("%s rd_r[%0d]", tag, k), rd_r, e.r);
                chk($sformatf("%s rd_i[%0d]", tag, k), rd_i, e.i);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            vt[k].addr  = 4'(k);
            vt[k].ld_r  = 18'(k);
            vt[k].ld_i  = 18'(-k);
            vt[k].rxv_r = 18'(100 + k);
            vt[k].rxv_i = 18'(200 + k);
            vt[k].tx_r  = 18'(k);
            vt[k].tx_i  = 18'(-k);
            vt[k].rd_r  = 18'(100 + k);
            vt[k].rd_i  = 18'(200 + k);
        end

        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk("rst busy", busy, 1'b0);
        chk("rst tx_valid", tx_valid, 1'b0);
        chk("rst tx_r", tx_r, '0);
        chk("rst tx_i", tx_i, '0);
        chk("rst done", done, 1'b0);
        chk("rst err_timeout", err_timeout, 1'b0);
        rd_addr = 4'd7;
        #1;
        chk("rst rd_r", rd_r, '0);
        chk("rst rd_i", rd_i, '0);

        // Basic burst, then contiguous result beats
        load_all();
        chk("load busy", busy, 1'b0);
        push_lead_and_matrix();
        do_start("b1");
        watch_burst("b1", -1);
        drive_rx("rx1", 0);
        read_check("rd1");

        // Fresh buffers; last load coincides with start; gapped result beats
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            load_entry(k);
            tick();
        end
        load_entry(15);
        push_lead_and_matrix();
        do_start("b2");
        watch_burst("b2", -1);
        drive_rx("rx2", 3);
        read_check("rd2");

        // start and load_we while busy, rx_valid in IDLE
        push_lead_and_matrix();
        do_start("b3");
        watch_burst("b3", 3);
        begin
            int extra = 0;
            for (int c = 0; c < 20; c++) begin
                if (tx_valid || done) extra++;
                tick();
            end
            chk("b3 no second burst", extra, 0);
        end
        drive_rx("rx3", 0);
        for (int c = 0; c < 3; c++) begin
            rx_valid = 1'b1;
            rx_r     = 18'sd999;
            rx_i     = -18'sd999;
            tick();
        end
        rx_valid = 1'b0;
        chk("idle rx busy", busy, 1'b0);
        read_check("rd3");
        push_lead_and_matrix();
        do_start("b4");
        watch_burst("b4", -1);
        drive_rx("rx4", 0);
        exp_rd.delete();

        // Reset mid-burst at sample 8
        push_lead_and_matrix();
        do_start("b5");
        for (int c = 0; c < 9; c++) tick();
        chk("pre-rst tx_r", tx_r, 18'sd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_tx.delete();
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst tx_valid", tx_valid, 1'b0);
        chk("mid rst tx_r", tx_r, '0);
        chk("mid rst tx_i", tx_i, '0);
        chk("mid rst done", done, 1'b0);
        rd_addr = 4'd0;
        #1;
        chk("mid rst rd_r", rd_r, '0);
        chk("mid rst rd_i", rd_i, '0);
        for (int b = 0; b < 16 + LEAD; b++) push_tx('0, '0);
        do_start("b6");
        watch_burst("b6", -1);

`ifdef MTX_HOST_TIMEOUT_EN
        // WAIT entered at the last observation; 64 idle cycles expire the watchdog
        begin
            int dones = 0;
            for (int c = 0; c < 63; c++) begin
                tick();
                if (done) dones++;
            end
            chk("to err before", err_timeout, 1'b0);
            chk("to busy before", busy, 1'b1);
            tick();
            if (done) dones++;
            chk("to err set", err_timeout, 1'b1);
            chk("to busy low", busy, 1'b0);
            chk("to no done", dones, 0);
            tick();
            chk("to err sticky", err_timeout, 1'b1);
            do_start("b7");
            chk("to err cleared", err_timeout, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
